// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage.
// Drives a 16-bit pc onto a shared instruction RAM. A read counts only when
// imem_req and imem_ack are both high in the same cycle, and the word it returns
// is presented on pc_out/instr_out one cycle later.
// A branch redirect always wins over anything else, and stall holds the
// presented instruction in place.
// Optional feature: define IF_FETCH_SKID_EN to add a one-entry skid buffer.
// With the buffer, a read can finish while stall is high; the word is parked
// and presented once stall drops. Without it, no read is requested while stall
// is high.
module if_fetch #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] br_target,
    input  logic              mem_busy,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(16'h0800);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0
`ifdef IF_FETCH_SKID_EN
        , S_FULL = 1'b1
`endif
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] pc_p0;
    logic              rd_fire;
    logic              present_fetch;
    logic              capture_skid;
    logic              present_skid;

`ifdef IF_FETCH_SKID_EN
    logic [DATA_W-1:0] skid_pc_p0;
    logic [DATA_W-1:0] skid_instr_p0;
`endif

    assign imem_addr = pc_p0;

    // Next-state, request and datapath-control decode.
    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        rd_fire       = 1'b0;
        present_fetch = 1'b0;
        capture_skid  = 1'b0;
        present_skid  = 1'b0;
        case (state_q)
            S_FETCH: begin
`ifdef IF_FETCH_SKID_EN
                imem_req = rst && !mem_busy;
`else
                imem_req = rst && !mem_busy && !stall;
`endif
                rd_fire = imem_req && imem_ack;
                if (!br_taken && rd_fire) begin
                    present_fetch = !stall;
`ifdef IF_FETCH_SKID_EN
                    // Read finished under stall: park the word until stall drops.
                    capture_skid = stall;
                    state_d      = stall ? S_FULL : S_FETCH;
`endif
                end
            end
`ifdef IF_FETCH_SKID_EN
            S_FULL: begin
                if (!br_taken && !stall) begin
                    present_skid = 1'b1;
                    state_d      = S_FETCH;
                end
            end
`endif
            default: state_d = S_FETCH;
        endcase
        // A redirect discards any same-cycle ack and any parked word.
        if (br_taken) begin
            state_d = S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // pc and the presented IF/ID register; a redirect loads pc and injects a NOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0       <= '0;
            pc_out      <= '0;
            instr_out   <= NOP;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= !br_taken && (present_fetch || present_skid);
            if (br_taken) begin
                pc_p0     <= br_target;
                pc_out    <= '0;
                instr_out <= NOP;
            end else begin
                if (present_fetch) begin
                    pc_out    <= pc_p0;
                    instr_out <= imem_rdata;
                end
                if (present_fetch || capture_skid) begin
                    pc_p0 <= pc_p0 + DATA_W'(1);
                end
`ifdef IF_FETCH_SKID_EN
                if (present_skid) begin
                    pc_out    <= skid_pc_p0;
                    instr_out <= skid_instr_p0;
                end
`endif
            end
        end
    end

`ifdef IF_FETCH_SKID_EN
    // Skid buffer contents; occupancy is tracked by the S_FULL state.
    always_ff @(posedge clk) begin
        if (capture_skid) begin
            skid_pc_p0    <= pc_p0;
            skid_instr_p0 <= imem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a table of directed per-cycle vectors plus
// a hand-written back-to-back and hold sequence.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        mem_busy = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] pc_out;
    logic [15:0] instr_out;
    logic        instr_valid;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_busy   (mem_busy),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .instr_out  (instr_out),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        busy;
        logic        ack;
        logic [15:0] rdata;
        logic        chk_addr;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic br, input logic [15:0] tgt,
                       input logic busy, input logic ack, input logic [15:0] rd,
                       input logic ca, input logic ereq, input logic [15:0] eaddr,
                       input logic ev, input logic [15:0] epc, input logic [15:0] ei);
        vec_t v;
        v.rst = r; v.stall = st; v.br = br; v.tgt = tgt; v.busy = busy;
        v.ack = ack; v.rdata = rd; v.chk_addr = ca; v.e_req = ereq; v.e_addr = eaddr;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle, then
    // check registered outputs just after the next rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        rst = v.rst; stall = v.stall; br_taken = v.br; br_target = v.tgt;
        mem_busy = v.busy; imem_ack = v.ack; imem_rdata = v.rdata;
        #4;
        chk("imem_req", idx, {15'd0, imem_req}, {15'd0, v.e_req});
        if (v.chk_addr) chk("imem_addr", idx, imem_addr, v.e_addr);
        @(posedge clk);
        #1;
        chk("instr_valid", idx, {15'd0, instr_valid}, {15'd0, v.e_valid});
        chk("pc_out", idx, pc_out, v.e_pc);
        chk("instr_out", idx, instr_out, v.e_instr);
    endtask

    initial begin
        //   rst st br tgt       busy ack rdata     ca req addr      vld pc_out    instr
        // Reset
        add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0800);
        add(0, 0, 0, 16'h0000, 0, 1, 16'hEEEE, 1, 0, 16'h0000, 0, 16'h0000, 16'h0800);
        // Zero-wait acks 0x1111, 0x2222
        add(1, 0, 0, 16'h0000, 0, 1, 16'h1111, 1, 1, 16'h0000, 1, 16'h0000, 16'h1111);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h2222, 1, 1, 16'h0001, 1, 16'h0001, 16'h2222);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0001, 16'h2222);
        // Walk pc to 0x0005
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0A02, 1, 1, 16'h0002, 1, 16'h0002, 16'h0A02);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0A03, 1, 1, 16'h0003, 1, 16'h0003, 16'h0A03);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0A04, 1, 1, 16'h0004, 1, 16'h0004, 16'h0A04);
        // Ack delayed 3 cycles at pc 0x0005
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h0004, 16'h0A04);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h0004, 16'h0A04);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0005, 0, 16'h0004, 16'h0A04);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h5555, 1, 1, 16'h0005, 1, 16'h0005, 16'h5555);
        // Branch to 0x0010 with a same-cycle ack that must be dropped
        add(1, 0, 1, 16'h0010, 0, 1, 16'hBBBB, 1, 1, 16'h0006, 0, 16'h0000, 16'h0800);
        // mem_busy for 2 cycles at 0x0010 (ack during busy is not a counted read)
        add(1, 0, 0, 16'h0000, 1, 1, 16'hDEAD, 1, 0, 16'h0010, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0010, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h1010, 1, 1, 16'h0010, 1, 16'h0010, 16'h1010);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h1011, 1, 1, 16'h0011, 1, 16'h0011, 16'h1011);
        // Branch to 0x0040 with same-cycle ack of 0xAAAA
        add(1, 0, 1, 16'h0040, 0, 1, 16'hAAAA, 1, 1, 16'h0012, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0800);
        // Branch to 0x0020, then stall 2 cycles during an ack of 0x3333
        add(1, 0, 1, 16'h0020, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 16'h0800);
`ifdef IF_FETCH_SKID_EN
        add(1, 1, 0, 16'h0000, 0, 1, 16'h3333, 1, 1, 16'h0020, 0, 16'h0000, 16'h0800);
        add(1, 1, 0, 16'h0000, 0, 1, 16'h4444, 1, 0, 16'h0021, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h4444, 1, 0, 16'h0021, 1, 16'h0020, 16'h3333);
`else
        add(1, 1, 0, 16'h0000, 0, 1, 16'h3333, 1, 0, 16'h0020, 0, 16'h0000, 16'h0800);
        add(1, 1, 0, 16'h0000, 0, 1, 16'h3333, 1, 0, 16'h0020, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h3333, 1, 1, 16'h0020, 1, 16'h0020, 16'h3333);
`endif
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0021, 0, 16'h0020, 16'h3333);
        // pc 0xFFFF ack, wrap, then reset mid-request with a late ack
        add(1, 0, 1, 16'hFFFF, 0, 0, 16'h0000, 1, 1, 16'h0021, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h7777, 1, 1, 16'hFFFF, 1, 16'hFFFF, 16'h7777);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h9999, 1, 0, 16'h0000, 0, 16'h0000, 16'h0800);
        add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0800);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Hand-written: four back-to-back zero-wait acks from pc 0x0000.
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1; stall = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
            imem_ack = 1'b1; imem_rdata = 16'hC000 + 16'(i);
            @(posedge clk);
            #1;
            chk("b2b_valid", 100 + i, {15'd0, instr_valid}, 16'h0001);
            chk("b2b_pc_out", 100 + i, pc_out, 16'(i));
            chk("b2b_instr", 100 + i, instr_out, 16'hC000 + 16'(i));
        end

        // Hand-written: stall with no ack keeps the last presentation steady.
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 200 + i, {15'd0, instr_valid}, 16'h0000);
            chk("hold_pc_out", 200 + i, pc_out, 16'h0003);
            chk("hold_instr", 200 + i, instr_out, 16'hC003);
            chk("hold_addr", 200 + i, imem_addr, 16'h0004);
        end
        stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
